// File: rtl/line_pixel_assembler.sv
// Pairs high/low bytes from the controller's line writes into RGB565 pixels
// and tracks in-order completion of each 64-pixel row.
module line_pixel_assembler #(
    parameter int unsigned ROW_WIDTH   = 5,
    parameter int unsigned PIXEL_WIDTH = 6,
    parameter int unsigned BYTE_WIDTH  = 8
) (
    input  logic                               ram_clk_enable,
    input  logic                               reset,
    input  logic [BYTE_WIDTH-1:0]              ram_data_out,
    input  logic [ROW_WIDTH+PIXEL_WIDTH:0]     ram_address,
    input  logic                               ram_write_enable,
    output logic [ROW_WIDTH+PIXEL_WIDTH-1:0]   pix_address,
    output logic [2*BYTE_WIDTH-1:0]            pix_data,
    output logic                               pix_write,
    output logic                               row_done_toggle,
    output logic [ROW_WIDTH-1:0]               row_done_row,
    output logic [(1<<ROW_WIDTH)-1:0]          row_valid,
    output logic                               pair_error
);

    localparam int unsigned NEXT_WIDTH = PIXEL_WIDTH + 1;
    localparam logic [PIXEL_WIDTH-1:0] LAST_PIXEL = PIXEL_WIDTH'((1 << PIXEL_WIDTH) - 1);

    typedef enum logic {
        IDLE,
        HAVE_HIGH
    } state_t;

    state_t                  state;
    logic [BYTE_WIDTH-1:0]   hi_byte;
    logic [ROW_WIDTH-1:0]    hold_row;
    logic [PIXEL_WIDTH-1:0]  hold_pixel;
    logic [ROW_WIDTH-1:0]    cur_row;
    logic [NEXT_WIDTH-1:0]   next_pixel;
    logic                    row_broken;

    logic [ROW_WIDTH-1:0]    row;
    logic [PIXEL_WIDTH-1:0]  pixel;
    logic                    byte_sel;
    logic                    pair_match;
    logic                    in_sequence;

    assign row         = ram_address[ROW_WIDTH+PIXEL_WIDTH:PIXEL_WIDTH+1];
    assign pixel       = ram_address[PIXEL_WIDTH:1];
    assign byte_sel    = ram_address[0];
    assign pair_match  = (row == hold_row) && (pixel == hold_pixel);
    assign in_sequence = (row == cur_row) && ({1'b0, pixel} == next_pixel) && !row_broken;

    always_ff @(posedge ram_clk_enable or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            hi_byte         <= '0;
            hold_row        <= '0;
            hold_pixel      <= '0;
            cur_row         <= '0;
            next_pixel      <= '0;
            row_broken      <= 1'b0;
            pix_address     <= '0;
            pix_data        <= '0;
            pix_write       <= 1'b0;
            row_done_toggle <= 1'b0;
            row_done_row    <= '0;
            row_valid       <= '0;
            pair_error      <= 1'b0;
        end else begin
            pix_write <= 1'b0;
            if (ram_write_enable) begin
                if (byte_sel) begin
                    // A high byte always (re)loads the holding register; a second one is a protocol error.
                    if (state == HAVE_HIGH) begin
                        pair_error <= 1'b1;
                    end
                    hi_byte    <= ram_data_out;
                    hold_row   <= row;
                    hold_pixel <= pixel;
                    state      <= HAVE_HIGH;
                    if (pixel == '0) begin
                        cur_row        <= row;
                        next_pixel     <= '0;
                        row_broken     <= 1'b0;
                        row_valid[row] <= 1'b0;
                    end
                end else if (state == IDLE) begin
                    pair_error <= 1'b1;
                end else if (pair_match) begin
                    pix_data    <= {hi_byte, ram_data_out};
                    pix_address <= {row, pixel};
                    pix_write   <= 1'b1;
                    state       <= IDLE;
                    if (in_sequence) begin
                        next_pixel <= next_pixel + NEXT_WIDTH'(1);
                        if (pixel == LAST_PIXEL) begin
                            row_valid[row]  <= 1'b1;
                            row_done_row    <= row;
                            row_done_toggle <= ~row_done_toggle;
                        end
                    end else begin
                        row_broken <= 1'b1;
                    end
                end else begin
                    pair_error <= 1'b1;
                    row_broken <= 1'b1;
                    state      <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_pixel_assembler.sv
// Directed bench for line_pixel_assembler: full rows, orphan/double bytes,
// skipped pixels, row rewrite and mid-pair reset.
module tb_line_pixel_assembler;

    logic        ram_clk_enable = 1'b0;
    logic        reset          = 1'b1;
    logic [7:0]  ram_data_out   = '0;
    logic [11:0] ram_address    = '0;
    logic        ram_write_enable = 1'b0;
    logic [10:0] pix_address;
    logic [15:0] pix_data;
    logic        pix_write;
    logic        row_done_toggle;
    logic [4:0]  row_done_row;
    logic [31:0] row_valid;
    logic        pair_error;

    int n_cmp = 0;
    int n_err = 0;
    int pulses;
    logic [10:0] p10_addr;
    logic [15:0] p10_data;

    line_pixel_assembler dut (
        .ram_clk_enable   (ram_clk_enable),
        .reset            (reset),
        .ram_data_out     (ram_data_out),
        .ram_address      (ram_address),
        .ram_write_enable (ram_write_enable),
        .pix_address      (pix_address),
        .pix_data         (pix_data),
        .pix_write        (pix_write),
        .row_done_toggle  (row_done_toggle),
        .row_done_row     (row_done_row),
        .row_valid        (row_valid),
        .pair_error       (pair_error)
    );

    always #5 ram_clk_enable = ~ram_clk_enable;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge ram_clk_enable);
        ram_write_enable = 1'b0;
        reset = 1'b1;
        @(negedge ram_clk_enable);
        @(negedge ram_clk_enable);
        reset = 1'b0;
    endtask

    // One byte write: drive at the falling edge, sample #1 after the rising edge.
    task automatic write_byte(input int row, input int pixel, input int sel, input int data);
        @(negedge ram_clk_enable);
        ram_address      = 12'((row << 7) | (pixel << 1) | sel);
        ram_data_out     = 8'(data);
        ram_write_enable = 1'b1;
        @(posedge ram_clk_enable);
        #1;
        if (pix_write) pulses++;
        ram_write_enable = 1'b0;
    endtask

    // Writes pixels 0..63 of a row in controller order, skipping pixel 'skip' (-1 = none).
    task automatic full_line(input int row, input int skip);
        pulses = 0;
        for (int p = 0; p < 64; p++) begin
            if (p != skip) begin
                write_byte(row, p, 1, 'hA0 + p);
                write_byte(row, p, 0, p);
                if (p == 10) begin
                    p10_addr = pix_address;
                    p10_data = pix_data;
                end
            end
        end
    endtask

    initial begin
        do_reset();
        #1;
        check_eq("rst_pix_address", 32'(pix_address), 32'h0);
        check_eq("rst_pix_data", 32'(pix_data), 32'h0);
        check_eq("rst_pix_write", 32'(pix_write), 32'h0);
        check_eq("rst_toggle", 32'(row_done_toggle), 32'h0);
        check_eq("rst_done_row", 32'(row_done_row), 32'h0);
        check_eq("rst_row_valid", row_valid, 32'h0);
        check_eq("rst_pair_error", 32'(pair_error), 32'h0);

        // Full line on row 5
        full_line(5, -1);
        check_eq("full_pulses", 32'(pulses), 32'd64);
        check_eq("full_p10_addr", 32'(p10_addr), 32'h14A);
        check_eq("full_p10_data", 32'(p10_data), 32'hAA0A);
        check_eq("full_row_valid", row_valid, 32'h0000_0020);
        check_eq("full_done_row", 32'(row_done_row), 32'd5);
        check_eq("full_toggle", 32'(row_done_toggle), 32'h1);
        check_eq("full_pair_error", 32'(pair_error), 32'h0);
        @(posedge ram_clk_enable); #1;
        check_eq("pix_write_clears", 32'(pix_write), 32'h0);

        // Orphan low byte, then row 3 still completes
        do_reset();
        pulses = 0;
        write_byte(3, 0, 0, 'h55);
        check_eq("orphan_pair_error", 32'(pair_error), 32'h1);
        check_eq("orphan_no_write", 32'(pulses), 32'd0);
        full_line(3, -1);
        check_eq("orphan_row_valid", row_valid, 32'h0000_0008);
        check_eq("orphan_done_row", 32'(row_done_row), 32'd3);
        check_eq("orphan_toggle", 32'(row_done_toggle), 32'h1);

        // Skipped pixel 20 on row 7
        do_reset();
        full_line(7, 20);
        check_eq("skip_pulses", 32'(pulses), 32'd63);
        check_eq("skip_row_valid", row_valid, 32'h0);
        check_eq("skip_toggle", 32'(row_done_toggle), 32'h0);
        check_eq("skip_pair_error", 32'(pair_error), 32'h0);

        // Double high byte
        do_reset();
        write_byte(2, 4, 1, 'h11);
        check_eq("dbl_first_high_ok", 32'(pair_error), 32'h0);
        write_byte(2, 4, 1, 'h22);
        write_byte(2, 4, 0, 'h33);
        check_eq("dbl_pair_error", 32'(pair_error), 32'h1);
        check_eq("dbl_pix_data", 32'(pix_data), 32'h2233);
        check_eq("dbl_pix_address", 32'(pix_address), 32'h084);
        check_eq("dbl_pix_write", 32'(pix_write), 32'h1);

        // Mismatched low byte is discarded
        write_byte(2, 5, 1, 'h44);
        pulses = 0;
        write_byte(2, 6, 0, 'h66);
        check_eq("mismatch_no_write", 32'(pulses), 32'd0);

        // Rewriting pixel 0 invalidates a completed row
        do_reset();
        full_line(9, -1);
        check_eq("rewrite_valid_before", row_valid, 32'h0000_0200);
        write_byte(9, 0, 1, 'h77);
        check_eq("rewrite_valid_after", row_valid, 32'h0);

        // Reset mid-pair discards the held high byte
        do_reset();
        write_byte(1, 0, 1, 'h99);
        @(negedge ram_clk_enable);
        reset = 1'b1;
        #1;
        check_eq("midrst_pix_address", 32'(pix_address), 32'h0);
        check_eq("midrst_pix_data", 32'(pix_data), 32'h0);
        check_eq("midrst_row_valid", row_valid, 32'h0);
        check_eq("midrst_pair_error", 32'(pair_error), 32'h0);
        @(negedge ram_clk_enable);
        reset = 1'b0;
        pulses = 0;
        write_byte(1, 0, 0, 'h12);
        check_eq("midrst_low_error", 32'(pair_error), 32'h1);
        check_eq("midrst_low_no_write", 32'(pulses), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
